// File: rtl/lcv_mul_acc_pipe.sv
// Two-stage signed multiply-accumulate with valid/ready flow control, a persistent
// stage-2 accumulator, optional output saturation and a sticky accumulator overflow flag.
module lcv_mul_acc_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 33,
  parameter int ACC_WIDTH = 40,
  parameter int SAT_OUT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inp_valid,
  output logic                 inp_ready,
  input  logic [IN_WIDTH-1:0]  inp_a,
  input  logic [IN_WIDTH-1:0]  inp_b,
  input  logic [OUT_WIDTH-1:0] inp_c,
  input  logic [1:0]           inp_op,
  output logic                 outp_valid,
  input  logic                 outp_ready,
  output logic [OUT_WIDTH-1:0] outp_data,
  output logic                 outp_sat,
  output logic                 outp_acc_ovf
);

  if (ACC_WIDTH < 2*IN_WIDTH+1 || ACC_WIDTH < OUT_WIDTH) begin : g_bad_params
    $error("lcv_mul_acc_pipe: ACC_WIDTH too narrow for IN_WIDTH/OUT_WIDTH");
  end

  typedef enum logic [1:0] {OP_MUL = 2'd0, OP_MAC = 2'd1, OP_LOAD = 2'd2, OP_CLR = 2'd3} op_e;

  localparam int PW = 2*IN_WIDTH;
  localparam logic [ACC_WIDTH-1:0]        ONE  = ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] OMAX = $signed((ONE << (OUT_WIDTH-1)) - ONE);
  localparam logic signed [ACC_WIDTH-1:0] OMIN = ~OMAX;

  // vld_pipe_q[1] is the stage-1 valid, vld_pipe_q[2] drives outp_valid
  logic [2:1]                  vld_pipe_q;
  logic signed [PW-1:0]        s1_prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0] s1_c_q;
  op_e                         s1_op_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0]        data_q, data_d;
  logic                        sat_q, sat_d;

  logic                        en, accept;
  logic signed [ACC_WIDTH-1:0] p, add_x, sum, r;
  logic                        sum_ovf;

  assign en        = !vld_pipe_q[2] || outp_ready;
  assign inp_ready = en && !rst;
  assign accept    = inp_valid && inp_ready;
  assign prod_d    = PW'($signed(inp_a)) * PW'($signed(inp_b));

  assign outp_valid   = vld_pipe_q[2];
  assign outp_data    = data_q;
  assign outp_sat     = sat_q;
  assign outp_acc_ovf = ovf_q;

  // One shared adder: MAC adds the accumulator, MUL/LOAD add the addend
  always_comb begin
    p       = ACC_WIDTH'(s1_prod_q);
    add_x   = (s1_op_q == OP_MAC) ? acc_q : s1_c_q;
    sum     = add_x + p;
    sum_ovf = (add_x[ACC_WIDTH-1] == p[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != p[ACC_WIDTH-1]);
    r       = sum;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (s1_op_q)
      OP_MUL: ;
      OP_MAC, OP_LOAD: begin
        acc_d = sum;
        ovf_d = ovf_q || sum_ovf;
      end
      OP_CLR: begin
        r     = '0;
        acc_d = '0;
        ovf_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    data_d = r[OUT_WIDTH-1:0];
    sat_d  = 1'b0;
    if (SAT_OUT != 0) begin
      if (r > OMAX) begin
        data_d = OMAX[OUT_WIDTH-1:0];
        sat_d  = 1'b1;
      end else if (r < OMIN) begin
        data_d = OMIN[OUT_WIDTH-1:0];
        sat_d  = 1'b1;
      end
    end
  end

  // Global stall: everything advances only on en; reset overrides the hold
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_prod_q  <= '0;
      s1_c_q     <= '0;
      s1_op_q    <= OP_MUL;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      data_q     <= '0;
      sat_q      <= 1'b0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[1], accept};
      s1_prod_q  <= prod_d;
      s1_c_q     <= ACC_WIDTH'($signed(inp_c));
      s1_op_q    <= op_e'(inp_op);
      if (vld_pipe_q[1]) begin
        acc_q  <= acc_d;
        ovf_q  <= ovf_d;
        data_q <= data_d;
        sat_q  <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Directed bench for lcv_mul_acc_pipe: a saturating default build and a truncating
// build share one stimulus stream; expected values are hand-computed constants.
module tb_lcv_mul_acc_pipe;

  localparam logic [1:0] MUL = 2'd0, MAC = 2'd1, LOAD = 2'd2, CLR = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, inp_valid, outp_ready;
  logic signed [15:0] a, b;
  logic signed [32:0] c;
  logic [1:0]         op;

  logic               inp_ready, outp_valid, sat, ovf;
  logic signed [32:0] outp_data;
  logic               inp_ready2, outp_valid2, sat2, ovf2;
  logic signed [32:0] outp_data2;

  int errors = 0;
  int checks = 0;

  lcv_mul_acc_pipe dut (
    .clk(clk), .rst(rst), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .inp_a(a), .inp_b(b), .inp_c(c), .inp_op(op),
    .outp_valid(outp_valid), .outp_ready(outp_ready), .outp_data(outp_data),
    .outp_sat(sat), .outp_acc_ovf(ovf)
  );

  lcv_mul_acc_pipe #(.SAT_OUT(0)) dut_nosat (
    .clk(clk), .rst(rst), .inp_valid(inp_valid), .inp_ready(inp_ready2),
    .inp_a(a), .inp_b(b), .inp_c(c), .inp_op(op),
    .outp_valid(outp_valid2), .outp_ready(outp_ready), .outp_data(outp_data2),
    .outp_sat(sat2), .outp_acc_ovf(ovf2)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat with the consumer ready; it must be taken at the next edge
  task automatic beat(input logic [1:0] o, input int av, input int bv, input logic signed [32:0] cv);
    inp_valid  = 1'b1;
    op         = o;
    a          = av[15:0];
    b          = bv[15:0];
    c          = cv;
    outp_ready = 1'b1;
    #1;
    chk("beat_ready", inp_ready, 1);
    tick();
    inp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  sent, recv, stalls;
    bit  took;

    // Reset, with a beat offered that must not be accepted
    rst = 1'b1; inp_valid = 1'b1; op = MUL; a = 16'sd5; b = 16'sd5; c = '0; outp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_inp_ready", inp_ready, 0);
    chk("rst_valid", outp_valid, 0);
    chk("rst_data", outp_data, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0; inp_valid = 1'b0;
    #1;
    chk("post_rst_ready", inp_ready, 1);
    tick();
    chk("post_rst_valid", outp_valid, 0);

    // MUL with addend, latency
    beat(MUL, -32768, -32768, 33'sd5);
    chk("mul_not_yet", outp_valid, 0);
    tick();
    chk("mul_valid", outp_valid, 1);
    chk("mul_data", outp_data, 64'sd1073741829);
    chk("mul_sat", sat, 0);
    tick();
    chk("mul_bubble", outp_valid, 0);

    // CLR then back-to-back MACs; interleaved MUL leaves the accumulator alone
    beat(CLR, 0, 0, '0);
    beat(MAC, -32768, -32768, '0);
    chk("clr_data", outp_data, 0);
    beat(MAC, -32768, -32768, '0);
    chk("mac1", outp_data, 64'sd1073741824);
    beat(MAC, -32768, -32768, '0);
    chk("mac2", outp_data, 64'sd2147483648);
    beat(MAC, -32768, -32768, '0);
    chk("mac3", outp_data, 64'sd3221225472);
    beat(MUL, 1, 1, '0);
    chk("mac4_sat_data", outp_data, 64'sd4294967295);
    chk("mac4_sat_flag", sat, 1);
    chk("mac4_trunc_data", outp_data2, -64'sd4294967296);
    chk("mac4_trunc_sat", sat2, 0);
    beat(MAC, 0, 0, '0);
    chk("mul_between", outp_data, 1);
    chk("mul_between_sat", sat, 0);
    tick();
    chk("mac5_data", outp_data, 64'sd4294967295);
    chk("mac5_sat", sat, 1);
    tick();
    chk("mac_drain", outp_valid, 0);

    // Backpressure: consumer stalls on loop cycles 3..5
    sent = 0; recv = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      outp_ready = !(cyc >= 3 && cyc <= 5);
      inp_valid  = (sent < 6);
      op = MUL; a = 16'(sent); b = 16'sd1; c = '0;
      #1;
      chk("bp_ready", inp_ready, (outp_valid && !outp_ready) ? 0 : 1);
      if (!inp_ready) stalls++;
      if (!outp_ready) chk("bp_hold", outp_data, 1);
      if (outp_valid && outp_ready) begin
        chk("bp_data", outp_data, recv);
        recv++;
      end
      took = inp_valid && inp_ready;
      tick();
      if (took) sent++;
    end
    inp_valid = 1'b0; outp_ready = 1'b1;
    chk("bp_recv", recv, 6);
    chk("bp_sent", sent, 6);
    chk("bp_stalls", stalls, 3);
    tick();
    chk("bp_drain", outp_valid, 0);

    // Accumulator wrap: 512 * 2^30 = 2^39 overflows a 40-bit signed accumulator
    beat(CLR, 0, 0, '0);
    for (int i = 0; i < 512; i++) beat(MAC, -32768, -32768, '0);
    chk("ovf_before", ovf, 0);
    tick();
    chk("ovf_wrap_data", outp_data, -64'sd4294967296);
    chk("ovf_wrap_sat", sat, 1);
    chk("ovf_set", ovf, 1);
    chk("ovf_wrap_trunc", outp_data2, 0);
    tick();
    chk("ovf_sticky_idle", ovf, 1);
    beat(MUL, 2, 3, '0);
    tick();
    chk("ovf_mul_data", outp_data, 6);
    chk("ovf_sticky_mul", ovf, 1);
    beat(CLR, 0, 0, '0);
    tick();
    chk("ovf_clr_data", outp_data, 0);
    chk("ovf_clr_flag", ovf, 0);
    chk("ovf_clr_sat", sat, 0);

    // Truncating build: LOAD lands at 3*2^30, one more MAC crosses 2^32
    beat(LOAD, -32768, -32768, 33'sd2147483648);
    beat(MAC, -32768, -32768, '0);
    chk("load_data", outp_data, 64'sd3221225472);
    chk("load_trunc_data", outp_data2, 64'sd3221225472);
    chk("load_trunc_sat", sat2, 0);
    tick();
    chk("load_mac_trunc", outp_data2, -64'sd4294967296);
    chk("load_mac_trunc_sat", sat2, 0);
    chk("load_mac_sat", outp_data, 64'sd4294967295);

    // Reset with two beats in flight
    beat(MUL, 7, 7, '0);
    beat(MUL, 8, 8, '0);
    chk("inflight_data", outp_data, 49);
    rst = 1'b1; inp_valid = 1'b1; op = MUL; a = 16'sd100; b = 16'sd1; c = '0;
    #1;
    chk("midrst_ready", inp_ready, 0);
    tick();
    rst = 1'b0; inp_valid = 1'b0;
    chk("midrst_valid", outp_valid, 0);
    chk("midrst_ovf", ovf, 0);
    tick();
    chk("midrst_valid2", outp_valid, 0);
    tick();
    chk("midrst_valid3", outp_valid, 0);
    beat(MAC, 3, 4, '0);
    tick();
    chk("midrst_mac_valid", outp_valid, 1);
    chk("midrst_mac_data", outp_data, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
